// File: rtl/subtractor_16bit_serial_pkg.sv
// Shared definitions for the digit-serial subtractor: controller states and
// default operand/digit widths.
package subtractor_16bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_16bit_serial_sub_digit.sv
// One DIGIT-wide slice of x - y - bi; the extra MSB of the widened
// difference is the borrow out of the slice.
module sub_digit
  import subtractor_16bit_serial_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] full;

  assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d    = full[DIGIT-1:0];
  assign bo   = full[DIGIT];

endmodule

// File: rtl/subtractor_16bit_serial.sv
// Digit-serial subtractor: latches an operand set, subtracts one DIGIT slice
// per cycle LSB first, then holds the result until the consumer takes it.
module subtractor_16bit_serial
  import subtractor_16bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bo;
  logic             last_digit;

  assign last_digit = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = CALC;
      CALC:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Constant-base slice selection keeps the mux free of variable part-selects.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) begin
        slice_a = a_reg[i*DIGIT +: DIGIT];
        slice_b = b_reg[i*DIGIT +: DIGIT];
      end
    end
  end

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x  (slice_a),
    .y  (slice_b),
    .bi (borrow),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // The borrow register doubles as the running borrow and the final bout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        CALC: begin
          for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) diff_reg[i*DIGIT +: DIGIT] <= slice_d;
          end
          borrow <= slice_bo;
          cnt    <= last_digit ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_reg;
  assign bout     = borrow;
  assign overflow = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                    (diff_reg[WIDTH-1] != a_reg[WIDTH-1]);

endmodule
